// File: rtl/data_cache_if.sv
// CPU-side request/response bus plus block-wide backing-memory bus of the data cache.
// Pure wiring, no storage, so it adds no latency.
// Flow control: CPU side is gated by is_ready; memory side uses mem_req_valid/mem_req_ready and an unthrottled mem_resp_valid.
interface data_cache_if #(
  parameter int BLOCK_WORDS = 4
);
  localparam int LINE_W = 32 * BLOCK_WORDS;

  // CPU request
  logic              is_input_valid;
  logic [31:0]       addr;
  logic              cpu_we;
  logic [31:0]       din;

  // CPU response
  logic              is_ready;
  logic              is_output_valid;
  logic [31:0]       dout;
  logic              is_hit;

  // backing memory request
  logic              mem_req_valid;
  logic              mem_req_we;
  logic [31:0]       mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic              mem_req_ready;

  // backing memory response
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_data;

  // environment side: the CPU and the backing memory
  modport master (
    output is_input_valid, addr, cpu_we, din,
    input  is_ready, is_output_valid, dout, is_hit,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );

  // cache side
  modport slave (
    input  is_input_valid, addr, cpu_we, din,
    output is_ready, is_output_valid, dout, is_hit,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and a block-wide memory.
// Latency: hits complete 1 cycle after accept; misses complete 1 cycle after the fill response arrives.
// Backpressure: is_ready drops for the whole miss; memory requests are held stable until mem_req_ready.
module data_cache #(
  parameter int LINE_NUM    = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic          clk,
  input  logic          reset,
  data_cache_if.slave   bus
);
  localparam int IDX    = $clog2(LINE_NUM);
  localparam int WOFF   = $clog2(BLOCK_WORDS);
  localparam int OFF    = WOFF + 2;
  localparam int TAG    = 32 - OFF - IDX;
  localparam int LINE_W = 32 * BLOCK_WORDS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, WAIT_FILL} state_t;

  state_t state, state_nxt;

  logic [LINE_NUM-1:0] valid_q;
  logic [LINE_NUM-1:0] dirty_q;
  logic [TAG-1:0]      tag_q  [LINE_NUM];
  logic [LINE_W-1:0]   data_q [LINE_NUM];

  // the miss being serviced; only meaningful outside IDLE
  logic [31:0] req_addr_q;
  logic        req_we_q;
  logic [31:0] req_din_q;

  logic [WOFF-1:0] in_off, req_off;
  logic [IDX-1:0]  in_idx, req_idx;
  logic [TAG-1:0]  in_tag, req_tag;

  assign in_off  = bus.addr[OFF-1:2];
  assign in_idx  = bus.addr[OFF+IDX-1:OFF];
  assign in_tag  = bus.addr[31:OFF+IDX];
  assign req_off = req_addr_q[OFF-1:2];
  assign req_idx = req_addr_q[OFF+IDX-1:OFF];
  assign req_tag = req_addr_q[31:OFF+IDX];

  // byte-within-word bits carry no information for word accesses
  logic unused_byte_bits;
  assign unused_byte_bits = ^{bus.addr[1:0], req_addr_q[1:0]};

  logic accept, in_hit, hit_acc, miss_acc, fill;
  logic [31:0]       hit_word;
  logic [LINE_W-1:0] fill_line;

  // tag compare runs on the live inputs so a hit can answer next cycle
  assign accept   = bus.is_input_valid && (state == IDLE);
  assign in_hit   = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign hit_acc  = accept && in_hit;
  assign miss_acc = accept && !in_hit;
  assign fill     = (state == WAIT_FILL) && bus.mem_resp_valid;
  assign hit_word = data_q[in_idx][{in_off, 5'b0} +: 32];

  // returned line with the pending store word merged in
  always_comb begin
    fill_line = bus.mem_resp_data;
    if (req_we_q) fill_line[{req_off, 5'b0} +: 32] = req_din_q;
  end

  // state register and request latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_addr_q <= '0;
      req_we_q   <= 1'b0;
      req_din_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_addr_q <= bus.addr;
        req_we_q   <= bus.cpu_we;
        req_din_q  <= bus.din;
      end
    end
  end

  // next-state: a dirty victim must be written back before its slot is refilled
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (miss_acc)
                   state_nxt = (valid_q[in_idx] && dirty_q[in_idx]) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (bus.mem_req_ready) state_nxt = ALLOCATE;
      ALLOCATE:  if (bus.mem_req_ready) state_nxt = WAIT_FILL;
      WAIT_FILL: if (bus.mem_resp_valid) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // memory request outputs depend on state only, so they stay stable while stalled
  always_comb begin
    bus.is_ready      = (state == IDLE);
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_data  = '0;
    case (state)
      WRITEBACK: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        bus.mem_req_addr  = {tag_q[req_idx], req_idx, {OFF{1'b0}}};
        bus.mem_req_data  = data_q[req_idx];
      end
      ALLOCATE: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {req_tag, req_idx, {OFF{1'b0}}};
      end
      default: ;
    endcase
  end

  // line status bits: cleared on reset so every line starts invalid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[req_idx] <= 1'b1;
      dirty_q[req_idx] <= req_we_q;
    end else if (hit_acc && bus.cpu_we) begin
      dirty_q[in_idx] <= 1'b1;
    end
  end

  // tag and data arrays: contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[req_idx] <= fill_line;
      tag_q[req_idx]  <= req_tag;
    end else if (hit_acc && bus.cpu_we) begin
      data_q[in_idx][{in_off, 5'b0} +: 32] <= bus.din;
    end
  end

  // one completion pulse per request; stores return zero data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.is_output_valid <= 1'b0;
      bus.dout            <= '0;
      bus.is_hit          <= 1'b0;
    end else begin
      bus.is_output_valid <= 1'b0;
      if (hit_acc) begin
        bus.is_output_valid <= 1'b1;
        bus.is_hit          <= 1'b1;
        bus.dout            <= bus.cpu_we ? 32'h0 : hit_word;
      end else if (fill) begin
        bus.is_output_valid <= 1'b1;
        bus.is_hit          <= 1'b0;
        bus.dout            <= req_we_q ? 32'h0 : fill_line[{req_off, 5'b0} +: 32];
      end
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios then random traffic against a flat-memory model.
// Bench drives and samples on the falling clock edge.
// Backing memory applies random and forced mem_req_ready stalls and random response delays.
module tb_data_cache;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_cache_if #(.BLOCK_WORDS(4)) bus();
  data_cache #(.LINE_NUM(16), .BLOCK_WORDS(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // bmem: backing memory contents; cmem: what the CPU should observe. Keys are word addresses.
  logic [31:0] bmem [int unsigned];
  logic [31:0] cmem [int unsigned];
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [23:0] m_tag   [16];

  typedef struct { logic we; logic [31:0] addr; logic [127:0] data; } mreq_t;
  typedef struct { logic [31:0] dout; logic hit; int acc_cyc; } oexp_t;
  mreq_t exp_mem[$];
  oexp_t exp_out[$];

  function automatic logic [31:0] init_word(int unsigned wa);
    return (wa * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  function automatic logic [31:0] rd_b(int unsigned wa);
    return bmem.exists(wa) ? bmem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] rd_c(int unsigned wa);
    return cmem.exists(wa) ? cmem[wa] : init_word(wa);
  endfunction

  function automatic logic [127:0] blk_b(logic [31:0] ba);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = rd_b((ba >> 2) + i);
    return r;
  endfunction

  function automatic logic [127:0] blk_c(logic [31:0] ba);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = rd_c((ba >> 2) + i);
    return r;
  endfunction

  // predicts the effect of accepting a request at the coming rising edge
  task automatic model_accept(input logic [31:0] a, input logic we, input logic [31:0] d);
    int          idx;
    logic [23:0] tg;
    bit          hit;
    mreq_t       m;
    oexp_t       o;
    idx = int'(a[7:4]);
    tg  = a[31:8];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        m.we   = 1'b1;
        m.addr = {m_tag[idx], a[7:4], 4'h0};
        m.data = blk_c(m.addr);
        exp_mem.push_back(m);
      end
      m.we   = 1'b0;
      m.addr = {a[31:4], 4'h0};
      m.data = '0;
      exp_mem.push_back(m);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    o.hit     = hit;
    o.acc_cyc = cyc;
    if (we) begin
      cmem[a >> 2] = d;
      m_dirty[idx] = 1'b1;
      o.dout       = 32'h0;
    end else begin
      o.dout = rd_c(a >> 2);
    end
    exp_out.push_back(o);
  endtask

  // ---------------- backing memory + completion monitor ----------------
  int          stall_left = 0;
  bit          stalling = 0;
  bit          hold_resp = 0;
  bit          resp_pending = 0;
  int          resp_delay = 0;
  logic [31:0] resp_addr;
  int          rd_cnt = 0;
  int          wb_cnt = 0;
  logic        snap_we;
  logic [31:0] snap_addr;

  task automatic tick();
    oexp_t o;
    mreq_t m;
    @(negedge clk);
    cyc++;
    if (bus.is_output_valid) begin
      if (exp_out.size() == 0) check_eq("spurious_out", 1, 0);
      else begin
        o = exp_out.pop_front();
        check_eq("dout", bus.dout, o.dout);
        check_eq("is_hit", bus.is_hit, o.hit);
        if (o.hit) check_eq("hit_latency", cyc, o.acc_cyc + 1);
      end
    end
    bus.mem_resp_valid = 1'b0;
    if (resp_pending && !hold_resp) begin
      if (resp_delay == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = blk_b(resp_addr);
        resp_pending       = 0;
      end else resp_delay--;
    end
    bus.mem_req_ready = ($urandom_range(0, 3) != 0);
    if (bus.mem_req_valid) begin
      if (stall_left > 0) begin
        bus.mem_req_ready = 1'b0;
        if (!stalling) begin
          stalling  = 1;
          snap_we   = bus.mem_req_we;
          snap_addr = bus.mem_req_addr;
        end else begin
          check_eq("stall_we_stable", bus.mem_req_we, snap_we);
          check_eq("stall_addr_stable", bus.mem_req_addr, snap_addr);
        end
        check_eq("stall_no_out", bus.is_output_valid, 0);
        stall_left--;
      end else begin
        if (stalling) begin
          bus.mem_req_ready = 1'b1;
          stalling = 0;
        end
        if (bus.mem_req_ready) begin
          if (exp_mem.size() == 0) check_eq("unexpected_mem_req", 1, 0);
          else begin
            m = exp_mem.pop_front();
            check_eq("mem_req_we", bus.mem_req_we, m.we);
            check_eq("mem_req_addr", bus.mem_req_addr, m.addr);
            if (m.we) check_eq("wb_data", bus.mem_req_data, m.data);
          end
          if (bus.mem_req_we) begin
            wb_cnt++;
            for (int i = 0; i < 4; i++) bmem[(bus.mem_req_addr >> 2) + i] = bus.mem_req_data[32*i +: 32];
          end else begin
            rd_cnt++;
            resp_pending = 1;
            resp_delay   = $urandom_range(0, 2);
            resp_addr    = bus.mem_req_addr;
          end
        end
      end
    end
  endtask

  // presents a request and holds it until the cache takes it
  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] d);
    int guard;
    guard = 0;
    bus.is_input_valid = 1'b1;
    bus.addr   = a;
    bus.cpu_we = we;
    bus.din    = d;
    while (!bus.is_ready) begin
      tick();
      guard++;
      if (guard > 200) begin
        check_eq("ready_timeout", 0, 1);
        return;
      end
    end
    model_accept(a, we, d);
    tick();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    bus.is_input_valid = 1'b0;
    while (exp_out.size() > 0 && guard < 300) begin
      tick();
      guard++;
    end
    if (exp_out.size() > 0) check_eq("drain_timeout", exp_out.size(), 0);
    repeat (2) tick();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_is_ready"}, bus.is_ready, 1);
    check_eq({pfx, "_out_valid"}, bus.is_output_valid, 0);
    check_eq({pfx, "_dout"}, bus.dout, 0);
    check_eq({pfx, "_is_hit"}, bus.is_hit, 0);
    check_eq({pfx, "_mem_req_valid"}, bus.mem_req_valid, 0);
    check_eq({pfx, "_mem_req_we"}, bus.mem_req_we, 0);
    check_eq({pfx, "_mem_req_addr"}, bus.mem_req_addr, 0);
  endtask

  initial begin
    int          r0;
    int          guard;
    logic [31:0] a;
    reset              = 1'b0;
    bus.is_input_valid = 1'b0;
    bus.addr           = '0;
    bus.cpu_we         = 1'b0;
    bus.din            = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    for (int i = 0; i < 4; i++) begin
      bmem[4 + i] = {4{4'(i + 1)}} * 32'h11111111 / 32'h11111111 * 32'h11111111;
      bmem[8 + i] = 32'h0;
    end
    cmem = bmem;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = '0;
    end

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // first load misses and fills block 0x10
    issue(32'h14, 1'b0, 32'h0);
    check_eq("miss_ready_low", bus.is_ready, 0);
    drain();
    check_eq("first_rd_cnt", rd_cnt, 1);
    check_eq("first_wb_cnt", wb_cnt, 0);

    // back-to-back hits in the filled line
    issue(32'h18, 1'b0, 32'h0);
    issue(32'h1C, 1'b0, 32'h0);
    issue(32'h10, 1'b0, 32'h0);
    drain();
    check_eq("hits_rd_cnt", rd_cnt, 1);

    // dirty the line, then evict it with a conflicting tag
    issue(32'h14, 1'b1, 32'h12345678);
    issue(32'h114, 1'b0, 32'h0);
    drain();
    check_eq("evict_wb_cnt", wb_cnt, 1);
    check_eq("evict_rd_cnt", rd_cnt, 2);
    check_eq("evict_bmem_word1", bmem[5], 32'h12345678);

    // five-cycle stall while the read request is outstanding
    stall_left = 5;
    issue(32'h224, 1'b0, 32'h0);
    drain();
    check_eq("stall_rd_cnt", rd_cnt, 3);

    // store miss onto a clean victim, then read it back as a hit
    issue(32'h28, 1'b1, 32'hCAFEF00D);
    issue(32'h28, 1'b0, 32'h0);
    drain();

    // random traffic over four tags to mix hits, clean and dirty misses
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.is_input_valid = 1'b0;
        tick();
      end
      a = $urandom & 32'h0000_03FC;
      issue(a, 1'($urandom_range(0, 1)), $urandom);
    end
    drain();

    // reset while waiting for a fill
    hold_resp = 1;
    issue(32'h5000, 1'b0, 32'h0);
    bus.is_input_valid = 1'b0;
    guard = 0;
    while (!resp_pending && guard < 100) begin
      tick();
      guard++;
    end
    check_eq("fill_wait_reached", resp_pending, 1);
    tick();
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_out.delete();
    exp_mem.delete();
    resp_pending = 0;
    hold_resp    = 0;
    stalling     = 0;
    stall_left   = 0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    cmem = bmem;
    tick();
    reset = 1'b1;
    tick();
    r0 = rd_cnt;
    issue(32'h14, 1'b0, 32'h0);
    drain();
    check_eq("post_rst_miss", rd_cnt, r0 + 1);
    check_eq("mem_queue_empty", exp_mem.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // absolute time limit in case the stimulus itself gets stuck
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
